wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_wb_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter downstream of the commit stage.
// Four commit streams (ALU, LD, CSR, FPU = channel 0..3) compete for one
// registered, stallable writeback port. Entries without a register
// destination are consumed immediately and never reach the output.
//
// Handshake (every valid/ready pair in this block): a transfer happens in a
// cycle where valid && ready at the rising clock edge. A producer holds valid
// and all fields stable until that transfer; ready may depend on valid
// combinationally but valid never depends on ready.
module wb_arbiter #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_WARPS   = 4,
    parameter int NR_BITS     = 6,
    parameter int CORE_ID     = 0,
    localparam int NW_BITS    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int DW         = NUM_THREADS * 32
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [NW_BITS-1:0]     alu_wid,
    input  logic [31:0]            alu_PC,
    input  logic [NUM_THREADS-1:0] alu_tmask,
    input  logic                   alu_wb,
    input  logic [NR_BITS-1:0]     alu_rd,
    input  logic [DW-1:0]          alu_data,

    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [NW_BITS-1:0]     ld_wid,
    input  logic [31:0]            ld_PC,
    input  logic [NUM_THREADS-1:0] ld_tmask,
    input  logic                   ld_wb,
    input  logic [NR_BITS-1:0]     ld_rd,
    input  logic [DW-1:0]          ld_data,

    input  logic                   csr_valid,
    output logic                   csr_ready,
    input  logic [NW_BITS-1:0]     csr_wid,
    input  logic [31:0]            csr_PC,
    input  logic [NUM_THREADS-1:0] csr_tmask,
    input  logic                   csr_wb,
    input  logic [NR_BITS-1:0]     csr_rd,
    input  logic [DW-1:0]          csr_data,

    input  logic                   fpu_valid,
    output logic                   fpu_ready,
    input  logic [NW_BITS-1:0]     fpu_wid,
    input  logic [31:0]            fpu_PC,
    input  logic [NUM_THREADS-1:0] fpu_tmask,
    input  logic                   fpu_wb,
    input  logic [NR_BITS-1:0]     fpu_rd,
    input  logic [DW-1:0]          fpu_data,

    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [NW_BITS-1:0]     wb_wid,
    output logic [31:0]            wb_PC,
    output logic [NUM_THREADS-1:0] wb_tmask,
    output logic [NR_BITS-1:0]     wb_rd,
    output logic [DW-1:0]          wb_data,
    output logic [1:0]             wb_src
);

    // Channel-indexed views of the four input bundles.
    logic [3:0]             ch_valid;
    logic [3:0]             ch_wb;
    logic [NW_BITS-1:0]     ch_wid   [4];
    logic [31:0]            ch_pc    [4];
    logic [NUM_THREADS-1:0] ch_tmask [4];
    logic [NR_BITS-1:0]     ch_rd    [4];
    logic [DW-1:0]          ch_data  [4];
    logic [3:0]             ch_ready;

    assign ch_valid = {fpu_valid, csr_valid, ld_valid, alu_valid};
    assign ch_wb    = {fpu_wb, csr_wb, ld_wb, alu_wb};
    assign ch_wid   = '{alu_wid, ld_wid, csr_wid, fpu_wid};
    assign ch_pc    = '{alu_PC, ld_PC, csr_PC, fpu_PC};
    assign ch_tmask = '{alu_tmask, ld_tmask, csr_tmask, fpu_tmask};
    assign ch_rd    = '{alu_rd, ld_rd, csr_rd, fpu_rd};
    assign ch_data  = '{alu_data, ld_data, csr_data, fpu_data};

    assign alu_ready = ch_ready[0];
    assign ld_ready  = ch_ready[1];
    assign csr_ready = ch_ready[2];
    assign fpu_ready = ch_ready[3];

    // Output register and round-robin pointer (rr_q = highest-priority channel).
    logic                   valid_q, valid_d;
    logic [NW_BITS-1:0]     wid_q, wid_d;
    logic [31:0]            pc_q, pc_d;
    logic [NUM_THREADS-1:0] tmask_q, tmask_d;
    logic [NR_BITS-1:0]     rd_q, rd_d;
    logic [DW-1:0]          data_q, data_d;
    logic [1:0]             src_q, src_d;
    logic [1:0]             rr_q, rr_d;

    logic [3:0] req;
    logic       out_free;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic [1:0] scan_idx;

    assign req      = ch_valid & ch_wb;
    assign out_free = !valid_q || wb_ready;

    // Pick the first requester at or after rr_q; scanning from the far end
    // down lets the closest channel overwrite any later candidate.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        scan_idx    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            scan_idx = rr_q + 2'(i);
            if (req[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Non-writing entries drain unconditionally; writing entries only on grant.
    always_comb begin
        ch_ready = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            ch_ready[c] = !reset && ch_valid[c] &&
                          (!ch_wb[c] || (out_free && grant_valid && (grant_idx == 2'(c))));
        end
    end

    // Next-state of the output register: load on grant, drop valid when idle.
    always_comb begin
        valid_d = valid_q;
        wid_d   = wid_q;
        pc_d    = pc_q;
        tmask_d = tmask_q;
        rd_d    = rd_q;
        data_d  = data_q;
        src_d   = src_q;
        rr_d    = rr_q;
        if (out_free) begin
            if (grant_valid) begin
                valid_d = 1'b1;
                wid_d   = ch_wid[grant_idx];
                pc_d    = ch_pc[grant_idx];
                tmask_d = ch_tmask[grant_idx];
                rd_d    = ch_rd[grant_idx];
                data_d  = ch_data[grant_idx];
                src_d   = grant_idx;
                rr_d    = grant_idx + 2'd1;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // State update; reset discards any held entry and restores ALU priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            wid_q   <= '0;
            pc_q    <= '0;
            tmask_q <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            src_q   <= 2'd0;
            rr_q    <= 2'd0;
        end else begin
            valid_q <= valid_d;
            wid_q   <= wid_d;
            pc_q    <= pc_d;
            tmask_q <= tmask_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            src_q   <= src_d;
            rr_q    <= rr_d;
        end
    end

    assign wb_valid = valid_q;
    assign wb_wid   = wid_q;
    assign wb_PC    = pc_q;
    assign wb_tmask = tmask_q;
    assign wb_rd    = rd_q;
    assign wb_data  = data_q;
    assign wb_src   = src_q;

    // A stalled writeback entry must not change under the register file.
    a_stall_hold : assert property (@(posedge clk) disable iff (reset)
        (valid_q && !wb_ready) |=> (valid_q && $stable(rd_q) && $stable(src_q) && $stable(data_q)))
        else $error("wb_arbiter core %0d: stalled entry changed", CORE_ID);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a driver issues hand-planned commit entries
// and pushes the expected writeback into exp_q at grant time; a monitor pops
// and compares on every wb_valid && wb_ready transfer.
module tb_wb_arbiter;
  localparam int NT = 4;
  localparam int NW = 2;
  localparam int NR = 6;
  localparam int DW = NT * 32;
  localparam int W  = 2 + NW + 32 + NT + NR + DW;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // channel drive arrays, index 0..3 = alu, ld, csr, fpu
  logic          c_valid [4];
  logic          c_wb    [4];
  logic [NW-1:0] c_wid   [4];
  logic [31:0]   c_pc    [4];
  logic [NT-1:0] c_tmask [4];
  logic [NR-1:0] c_rd    [4];
  logic [DW-1:0] c_data  [4];
  logic          wb_ready;

  logic alu_ready, ld_ready, csr_ready, fpu_ready;
  logic          wb_valid;
  logic [NW-1:0] wb_wid;
  logic [31:0]   wb_PC;
  logic [NT-1:0] wb_tmask;
  logic [NR-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic [1:0]    wb_src;
  logic [3:0]    rdy;
  assign rdy = {fpu_ready, csr_ready, ld_ready, alu_ready};

  wb_arbiter #(.NUM_THREADS(NT), .NUM_WARPS(4), .NR_BITS(NR), .CORE_ID(0)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(c_valid[0]), .alu_ready(alu_ready), .alu_wid(c_wid[0]), .alu_PC(c_pc[0]),
    .alu_tmask(c_tmask[0]), .alu_wb(c_wb[0]), .alu_rd(c_rd[0]), .alu_data(c_data[0]),
    .ld_valid(c_valid[1]), .ld_ready(ld_ready), .ld_wid(c_wid[1]), .ld_PC(c_pc[1]),
    .ld_tmask(c_tmask[1]), .ld_wb(c_wb[1]), .ld_rd(c_rd[1]), .ld_data(c_data[1]),
    .csr_valid(c_valid[2]), .csr_ready(csr_ready), .csr_wid(c_wid[2]), .csr_PC(c_pc[2]),
    .csr_tmask(c_tmask[2]), .csr_wb(c_wb[2]), .csr_rd(c_rd[2]), .csr_data(c_data[2]),
    .fpu_valid(c_valid[3]), .fpu_ready(fpu_ready), .fpu_wid(c_wid[3]), .fpu_PC(c_pc[3]),
    .fpu_tmask(c_tmask[3]), .fpu_wb(c_wb[3]), .fpu_rd(c_rd[3]), .fpu_data(c_data[3]),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wid(wb_wid), .wb_PC(wb_PC),
    .wb_tmask(wb_tmask), .wb_rd(wb_rd), .wb_data(wb_data), .wb_src(wb_src)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_fail = 0;
  int tag = 1;
  logic [NR-1:0] last_rd;

  function automatic logic [W-1:0] pack(input logic [1:0] src, input logic [NW-1:0] wid,
                                        input logic [31:0] pc, input logic [NT-1:0] tm,
                                        input logic [NR-1:0] rd, input logic [DW-1:0] data);
    return {src, wid, pc, tm, rd, data};
  endfunction

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every completed writeback transfer is compared to the queue head
  always @(negedge clk) begin
    if (!reset && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_wb: got src %0d rd %0d expected nothing", wb_src, wb_rd);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        n_vec++;
        if (pack(wb_src, wb_wid, wb_PC, wb_tmask, wb_rd, wb_data) !== e) begin
          n_fail++;
          $display("FAIL wb_entry: got src %0d rd %0d pc %0h expected src %0d rd %0d pc %0h",
                   wb_src, wb_rd, wb_PC, e[W-1 -: 2], e[DW +: NR], e[DW+NR+NT +: 32]);
        end
      end
    end
  end

  // driver tasks
  task automatic load(input int c, input int t, input logic wb);
    c_valid[c] = 1'b1;
    c_wb[c]    = wb;
    c_wid[c]   = NW'(t);
    c_pc[c]    = 32'h1000 + 32'(t) * 4;
    c_tmask[c] = NT'(t) | 4'b0001;
    c_rd[c]    = NR'(t + 8);
    for (int l = 0; l < NT; l++) c_data[c][32*l +: 32] = 32'hA000_0000 + 32'(t) * 16 + 32'(l);
  endtask

  task automatic push_exp(input int c);
    exp_q.push_back(pack(2'(c), c_wid[c], c_pc[c], c_tmask[c], c_rd[c], c_data[c]));
    last_rd = c_rd[c];
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int c = 0; c < 4; c++) begin
      c_valid[c] = 1'b0; c_wb[c] = 1'b0; c_wid[c] = '0; c_pc[c] = '0;
      c_tmask[c] = '0; c_rd[c] = '0; c_data[c] = '0;
    end
    wb_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin load(c, tag, 1'b1); tag++; end

    // reset with every channel requesting
    @(negedge clk);
    chk("reset_ready", 192'(rdy), 192'(4'b0000));
    chk("reset_valid", 192'(wb_valid), 192'(0));
    chk("reset_fields", 192'({wb_src, wb_wid, wb_rd, wb_tmask, wb_PC}), 192'(0));
    chk("reset_data", 192'(wb_data), 192'(0));
    next_cycle();
    reset = 1'b0;

    // fairness: all four continuously requesting -> 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++) begin
      push_exp(k % 4);
      @(negedge clk);
      chk("rr_ready", 192'(rdy), 192'(4'b0001 << (k % 4)));
      next_cycle();
      load(k % 4, tag, 1'b1); tag++;
    end
    for (int c = 0; c < 4; c++) c_valid[c] = 1'b0;
    @(negedge clk);
    chk("idle_ready", 192'(rdy), 192'(0));
    next_cycle();
    @(negedge clk);
    chk("idle_valid", 192'(wb_valid), 192'(0));
    chk("idle_hold_rd", 192'(wb_rd), 192'(last_rd));

    // stall hold with zero-tmask csr entry, alu waiting, ld bypassing
    next_cycle();
    c_valid[2] = 1'b1; c_wb[2] = 1'b1; c_wid[2] = 2'd2; c_pc[2] = 32'h0000_2040;
    c_tmask[2] = 4'b0000; c_rd[2] = 6'd5;
    c_data[2] = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
    push_exp(2);
    @(negedge clk);
    chk("csr_grant", 192'(rdy), 192'(4'b0100));
    next_cycle();
    c_valid[2] = 1'b0;
    wb_ready = 1'b0;
    load(0, tag, 1'b1); tag++;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin load(1, tag, 1'b0); tag++; end
      else c_valid[1] = 1'b0;
      @(negedge clk);
      chk("stall_ready", 192'(rdy), (i == 1) ? 192'(4'b0010) : 192'(0));
      chk("stall_valid", 192'(wb_valid), 192'(1));
      chk("stall_fields", 192'({wb_src, wb_wid, wb_rd, wb_tmask}), 192'({2'd2, 2'd2, 6'd5, 4'b0000}));
      chk("stall_data0", 192'(wb_data[31:0]), 192'(32'hDEAD_BEEF));
      next_cycle();
    end
    c_valid[1] = 1'b0;
    wb_ready = 1'b1;
    push_exp(0);
    @(negedge clk);
    chk("unstall_alu", 192'(rdy), 192'(4'b0001));
    next_cycle();
    c_valid[0] = 1'b0;

    // fpu back-to-back stream, rd 1..5, no bubbles
    for (int k = 1; k <= 5; k++) begin
      load(3, tag, 1'b1); tag++;
      c_rd[3] = NR'(k);
      push_exp(3);
      @(negedge clk);
      chk("fpu_ready", 192'(rdy), 192'(4'b1000));
      if (k > 1) chk("fpu_stream", 192'({wb_valid, wb_rd}), 192'({1'b1, 6'(k - 1)}));
      next_cycle();
    end
    c_valid[3] = 1'b0;
    @(negedge clk);
    chk("fpu_last", 192'({wb_valid, wb_rd}), 192'({1'b1, 6'd5}));
    next_cycle();

    // pointer wrapped to alu: alu then ld then alu again
    load(0, tag, 1'b1); tag++;
    load(1, tag, 1'b1); tag++;
    push_exp(0);
    @(negedge clk);
    chk("wrap_alu", 192'(rdy), 192'(4'b0001));
    next_cycle();
    load(0, tag, 1'b1); tag++;
    push_exp(1);
    @(negedge clk);
    chk("wrap_ld", 192'(rdy), 192'(4'b0010));
    next_cycle();
    c_valid[1] = 1'b0;
    push_exp(0);
    @(negedge clk);
    chk("wrap_alu2", 192'(rdy), 192'(4'b0001));
    next_cycle();
    c_valid[0] = 1'b0;

    // drain with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 192'(exp_q.size()), 192'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
